// File: rtl/flash_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_req_ctrl
// Brief    : Host-side sequencer for flash_interface. Owns a DEPTH x 16
//            parameter buffer and turns save/load requests into wr/rd irq
//            pulses, streaming buffer words out and capturing read words.
//            Optional CRC-16-CCITT over loaded words: macro FLASH_REQ_CRC_EN.
// Revision : 1.0  initial release
// ============================================================================
module flash_req_ctrl #(
    parameter int ADDR_SZ     = 10,
    parameter int DEPTH       = 256,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_save_req,
    input  logic                       i_load_req,
    input  logic [ADDR_SZ-1:0]         i_base_addr,
    input  logic [ADDR_SZ-1:0]         i_len,
    input  logic                       i_buf_we,
    input  logic [$clog2(DEPTH)-1:0]   i_buf_addr,
    input  logic [15:0]                i_buf_wdata,
    output logic [15:0]                o_buf_rdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [15:0]                o_crc,
    output logic                       o_wr_irq,
    output logic                       o_rd_irq,
    output logic [ADDR_SZ-1:0]         o_flash_addr_offset,
    output logic [ADDR_SZ-1:0]         o_flash_data_len,
    output logic [15:0]                o_flash_wdata,
    input  logic                       i_flash_wr_en,
    input  logic [ADDR_SZ-1:0]         i_flash_waddr,
    input  logic                       i_wr_dn,
    input  logic [15:0]                i_flash_rdata,
    input  logic                       i_flash_rd_en,
    input  logic [ADDR_SZ-1:0]         i_flash_raddr,
    input  logic                       i_flash_read_done
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_SZ:0]     c_DEPTH_LEN = (ADDR_SZ + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd2;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd3;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd4;
    localparam logic [2:0] c_ST_FIN     = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                w_accept;
    logic                w_load_accept;
    logic                w_bad_len;
    logic                w_timeout;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic [ADDR_SZ-1:0]  r_offset;
    logic [ADDR_SZ-1:0]  r_len;
    logic [15:0]         r_wdata;
    logic [15:0]         r_buf_rdata;
    logic [15:0]         r_mem [DEPTH];

    logic [ADDR_SZ-1:0]  w_wdiff;
    logic [ADDR_SZ-1:0]  w_rdiff;
    logic [c_IDX_W-1:0]  w_widx;
    logic [c_IDX_W-1:0]  w_ridx;
    logic                w_flash_we;
    logic                w_host_we;
    logic                w_unused;

    // Wrap-around distance from the latched base, folded into the buffer.
    assign w_wdiff = i_flash_waddr - r_offset;
    assign w_rdiff = i_flash_raddr - r_offset;
    assign w_widx  = w_wdiff[c_IDX_W-1:0];
    assign w_ridx  = w_rdiff[c_IDX_W-1:0];

    assign w_flash_we = (r_state == c_ST_RD_WAIT) && i_flash_rd_en;
    assign w_host_we  = i_buf_we && !o_busy;

    assign w_unused = ^{i_flash_wr_en, w_wdiff, w_rdiff};

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_load_accept = 1'b0;
        w_bad_len     = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (i_save_req || i_load_req) begin
                    if ({1'b0, i_len} > c_DEPTH_LEN) begin
                        w_bad_len = 1'b1;
                    end else begin
                        w_accept      = 1'b1;
                        w_load_accept = !i_save_req;
                        if (i_len == '0)
                            w_state_nxt = c_ST_FIN;
                        else if (i_save_req)
                            w_state_nxt = c_ST_WR_REQ;
                        else
                            w_state_nxt = c_ST_RD_REQ;
                    end
                end
            end
            c_ST_WR_REQ: w_state_nxt = c_ST_WR_WAIT;
            c_ST_RD_REQ: w_state_nxt = c_ST_RD_WAIT;
            c_ST_WR_WAIT: begin
                if (i_wr_dn) begin
                    w_state_nxt = c_ST_FIN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_WAIT: begin
                if (i_flash_read_done) begin
                    w_state_nxt = c_ST_FIN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_FIN: w_state_nxt = c_ST_IDLE;
            default:  w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_offset <= '0;
            r_len    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_bad_len || w_timeout;
            if (w_accept) begin
                r_offset <= i_base_addr;
                r_len    <= i_len;
            end
            // Counter restarts as the REQ state hands over to its WAIT state.
            if ((r_state == c_ST_WR_REQ) || (r_state == c_ST_RD_REQ))
                r_cnt <= '0;
            else if ((r_state == c_ST_WR_WAIT) || (r_state == c_ST_RD_WAIT))
                r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_flash_we)
            r_mem[w_ridx] <= i_flash_rdata;
        else if (w_host_we)
            r_mem[i_buf_addr] <= i_buf_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_rdata <= '0;
            r_wdata     <= '0;
        end else begin
            r_buf_rdata <= r_mem[i_buf_addr];
            if (r_state == c_ST_WR_WAIT)
                r_wdata <= r_mem[w_widx];
        end
    end

`ifdef FLASH_REQ_CRC_EN
    logic [15:0] r_crc;

    function automatic logic [15:0] f_crc_word(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_crc <= '0;
        else if (w_load_accept)
            r_crc <= 16'hFFFF;
        else if (w_flash_we)
            r_crc <= f_crc_word(r_crc, i_flash_rdata);
    end

    assign o_crc = r_crc;
`else
    logic w_unused_crc;
    assign w_unused_crc = w_load_accept;
    assign o_crc        = 16'h0000;
`endif

    assign o_busy              = (r_state == c_ST_WR_REQ) || (r_state == c_ST_WR_WAIT) ||
                                 (r_state == c_ST_RD_REQ) || (r_state == c_ST_RD_WAIT);
    assign o_done              = (r_state == c_ST_FIN);
    assign o_wr_irq            = (r_state == c_ST_WR_REQ);
    assign o_rd_irq            = (r_state == c_ST_RD_REQ);
    assign o_err               = r_err;
    assign o_buf_rdata         = r_buf_rdata;
    assign o_flash_wdata       = r_wdata;
    assign o_flash_addr_offset = r_offset;
    assign o_flash_data_len    = r_len;

endmodule
`default_nettype wire
